// File: rtl/ysyx_22041211_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer:
// operation codes, FSM states, ALU controls and default widths.
package ysyx_22041211_muldiv_pkg;

   localparam int DATA_LEN_DEF = 32;
   localparam int STEPS_DEF    = 32;

   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_MULHU = 2'b01,
      OP_DIVU  = 2'b10,
      OP_REMU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;

   function automatic logic is_div(input op_e op);
      return (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/ysyx_22041211_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide. Purely combinational;
// the external ALU does the 32-bit add/subtract for the step.
module ysyx_22041211_muldiv_step
   import ysyx_22041211_muldiv_pkg::*;
#(
   parameter int DATA_LEN = DATA_LEN_DEF
) (
   input  logic                busy,
   input  op_e                 op,
   input  logic [DATA_LEN-1:0] acc,        // hi (multiply) / rem (divide)
   input  logic [DATA_LEN-1:0] sh,         // lo (multiply) / quo (divide)
   input  logic [DATA_LEN-1:0] opnd,       // mcand (multiply) / dvs (divide)
   input  logic [DATA_LEN-1:0] alu_result,
   output logic [DATA_LEN-1:0] alu_src1,
   output logic [DATA_LEN-1:0] alu_src2,
   output logic [3:0]          alu_control,
   output logic [DATA_LEN-1:0] acc_nxt,
   output logic [DATA_LEN-1:0] sh_nxt
);

   logic [DATA_LEN-1:0] r_shift;
   logic [DATA_LEN-1:0] s;
   logic                c;
   logic                b;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      alu_src1    = '0;
      alu_src2    = '0;
      alu_control = ALU_ADD;
      acc_nxt     = acc;
      sh_nxt      = sh;
      r_shift     = {acc[DATA_LEN-2:0], sh[DATA_LEN-1]};
      b           = acc[DATA_LEN-1];
      s           = acc;
      c           = 1'b0;

      if (busy) begin
         if (is_div(op)) begin
            alu_src1    = r_shift;
            alu_src2    = opnd;
            alu_control = ALU_SUB;
            // The bit shifted out of rem makes the partial remainder exceed dvs.
            if (b || !(r_shift < opnd)) begin
               acc_nxt = alu_result;
               sh_nxt  = {sh[DATA_LEN-2:0], 1'b1};
            end else begin
               acc_nxt = r_shift;
               sh_nxt  = {sh[DATA_LEN-2:0], 1'b0};
            end
         end else begin
            alu_src1    = acc;
            alu_src2    = opnd;
            alu_control = ALU_ADD;
            if (sh[0]) begin
               s = alu_result;
               c = (alu_result < acc);
            end
            // {hi,lo} <= {c,s,lo} >> 1
            acc_nxt = {c, s[DATA_LEN-1:1]};
            sh_nxt  = {s[0], sh[DATA_LEN-1:1]};
         end
      end
   end

endmodule

// File: rtl/ysyx_22041211_muldiv_ctrl.sv
// Iterative RV32M unsigned multiply/divide sequencer driving an external ALU.
// Optional YSYX_22041211_MULDIV_EARLY_EN: trivial operands finish at the handshake.
module ysyx_22041211_muldiv_ctrl
   import ysyx_22041211_muldiv_pkg::*;
#(
   parameter int DATA_LEN = DATA_LEN_DEF,
   parameter int STEPS    = STEPS_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          op,
   input  logic [DATA_LEN-1:0] src1,
   input  logic [DATA_LEN-1:0] src2,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_LEN-1:0] result,
   output logic [DATA_LEN-1:0] alu_src1,
   output logic [DATA_LEN-1:0] alu_src2,
   output logic [3:0]          alu_control,
   input  logic [DATA_LEN-1:0] alu_result
);

   localparam int CNT_W = $clog2(STEPS);

   state_e              state, state_nxt;
   op_e                 op_r;
   op_e                 op_in;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_LEN-1:0] acc, sh, opnd;
   logic [DATA_LEN-1:0] acc_nxt, sh_nxt;
   logic                accept;
   logic                early;
   logic                last_step;

   assign op_in     = op_e'(op);
   assign accept    = in_valid && (state == ST_IDLE);
   assign last_step = (cnt == CNT_W'(STEPS - 1));

`ifdef YSYX_22041211_MULDIV_EARLY_EN
   // Divide by zero is deliberately excluded: it takes the full loop.
   assign early = is_div(op_in) ? (src1 < src2)
                                : ((src1 == '0) || (src2 == '0));
`else
   assign early = 1'b0;
`endif

   ysyx_22041211_muldiv_step #(
      .DATA_LEN (DATA_LEN)
   ) u_step (
      .busy        (state == ST_BUSY),
      .op          (op_r),
      .acc         (acc),
      .sh          (sh),
      .opnd        (opnd),
      .alu_result  (alu_result),
      .alu_src1    (alu_src1),
      .alu_src2    (alu_src2),
      .alu_control (alu_control),
      .acc_nxt     (acc_nxt),
      .sh_nxt      (sh_nxt)
   );

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      result    = '0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = early ? ST_DONE : ST_BUSY;
         end
         ST_BUSY: begin
            if (last_step) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            result    = (op_r == OP_MUL || op_r == OP_DIVU) ? sh : acc;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         op_r  <= OP_MUL;
         cnt   <= '0;
         acc   <= '0;
         sh    <= '0;
         opnd  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_r <= op_in;
            cnt  <= '0;
            if (early) begin
               // Zero product, or quotient 0 with remainder = dividend.
               acc  <= is_div(op_in) ? src1 : '0;
               sh   <= '0;
               opnd <= '0;
            end else begin
               acc  <= '0;
               sh   <= is_div(op_in) ? src1 : src2;
               opnd <= is_div(op_in) ? src2 : src1;
            end
         end else if (state == ST_BUSY) begin
            acc <= acc_nxt;
            sh  <= sh_nxt;
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22041211_muldiv_ctrl.sv
// Directed self-checking bench for ysyx_22041211_muldiv_ctrl with a combinational ALU model.
module tb_ysyx_22041211_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op = 2'b00;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic [31:0] alu_src1;
   logic [31:0] alu_src2;
   logic [3:0]  alu_control;
   logic [31:0] alu_result;

   int n_vec  = 0;
   int n_miss = 0;

`ifdef YSYX_22041211_MULDIV_EARLY_EN
   localparam int EARLY_EDGES = 0;
`else
   localparam int EARLY_EDGES = 32;
`endif

   always #5 clk = ~clk;

   // ALU model: add or subtract as selected.
   always_comb alu_result = (alu_control == 4'b0001) ? (alu_src1 - alu_src2)
                                                     : (alu_src1 + alu_src2);

   ysyx_22041211_muldiv_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op          (op),
      .src1        (src1),
      .src2        (src2),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .alu_src1    (alu_src1),
      .alu_src2    (alu_src2),
      .alu_control (alu_control),
      .alu_result  (alu_result)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_edges, input int hold);
      int edges;
      logic [31:0] exp_ctl;
      exp_ctl = o[1] ? 32'd1 : 32'd0;
      @(negedge clk);
      check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1;
      op       = o;
      src1     = a;
      src2     = b;
      @(posedge clk);
      #1 in_valid = 1'b0;
      edges = 0;
      while (!out_valid && edges < 40) begin
         check({tag, ".alu_ctl"}, {28'b0, alu_control}, exp_ctl);
         @(posedge clk);
         #1 edges++;
      end
      check({tag, ".latency"}, edges, exp_edges);
      check({tag, ".result"}, result, exp_res);
      check({tag, ".busy_ready"}, {31'b0, in_ready}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, ".hold_valid"}, {31'b0, out_valid}, 32'd1);
         check({tag, ".hold_result"}, result, exp_res);
         check({tag, ".hold_ready"}, {31'b0, in_ready}, 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, ".out_valid_drop"}, {31'b0, out_valid}, 32'd0);
      check({tag, ".idle_ready"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      #12;
      check("rst.in_ready", {31'b0, in_ready}, 32'd1);
      check("rst.out_valid", {31'b0, out_valid}, 32'd0);
      check("rst.result", result, 32'd0);
      check("rst.alu_src1", alu_src1, 32'd0);
      check("rst.alu_ctl", {28'b0, alu_control}, 32'd0);
      rst_n = 1'b1;

      run_op("mul_7x6",      2'b00, 32'd7,        32'd6,        32'h0000002A, 32, 0);
      run_op("mulhu_ffxff",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, 0);
      run_op("mul_ffxff",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32, 0);
      run_op("mulhu_carry",  2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32, 0);
      run_op("mulhu_8000x4", 2'b01, 32'h80000000, 32'd4,        32'h00000002, 32, 0);
      run_op("divu_100_7",   2'b10, 32'd100,      32'd7,        32'h0000000E, 32, 5);
      run_op("remu_100_7",   2'b11, 32'd100,      32'd7,        32'h00000002, 32, 0);
      run_op("divu_by0",     2'b10, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32, 0);
      run_op("remu_by0",     2'b11, 32'h12345678, 32'd0,        32'h12345678, 32, 0);
      run_op("divu_max_1",   2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32, 0);
      run_op("divu_5_5",     2'b10, 32'd5,        32'd5,        32'h00000001, 32, 0);
      run_op("mul_0x5",      2'b00, 32'd0,        32'd5,        32'h00000000, EARLY_EDGES, 0);
      run_op("divu_3_10",    2'b10, 32'd3,        32'd10,       32'h00000000, EARLY_EDGES, 0);
      run_op("remu_3_10",    2'b11, 32'd3,        32'd10,       32'h00000003, EARLY_EDGES, 0);

      // Asynchronous reset in the middle of a divide.
      @(negedge clk);
      in_valid = 1'b1;
      op       = 2'b10;
      src1     = 32'd1000;
      src2     = 32'd3;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int i = 0; i < 10; i++) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst.out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst.in_ready", {31'b0, in_ready}, 32'd1);
      check("midrst.alu_ctl", {28'b0, alu_control}, 32'd0);
      check("midrst.alu_src2", alu_src2, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_rst_remu", 2'b11, 32'd1000, 32'd3, 32'h00000001, 32, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
